// File: rtl/booth_mult_32.sv
// booth_mult_32 : iterative radix-2 Booth signed multiplier, 32 x 32 -> low 32 bits.
// One Booth step per clock through a 32-bit carry-lookahead add/sub plus a
// sign-extension bit, then a 66-bit arithmetic right shift of {acc, q, q_m1}.
// Optional feature macro: MULT_OVF_DETECT_EN (registered signed-overflow flag).
module booth_mult_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             result_rdy,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             accept_s;
  logic             last_step_s;

  logic [WIDTH:0]   m_r;
  logic [WIDTH:0]   acc_r;
  logic [WIDTH-1:0] q_r;
  logic             qm1_r;
  logic [CNT_W-1:0] cnt_r;
  logic             result_rdy_r;
  logic [WIDTH-1:0] result_r;

  logic [WIDTH:0]   acc_sum_s;
  logic [WIDTH:0]   acc_sh_s;
  logic [WIDTH-1:0] q_sh_s;
  logic             qm1_sh_s;

  // 33-bit add/sub: low 32 bits via generate/propagate carry chain, bit 32
  // rebuilt from the sign bits and the carry out of bit 31 so M = -2^31 never wraps.
  function automatic logic [WIDTH:0] addsub33(input logic [WIDTH:0] a,
                                              input logic [WIDTH:0] b,
                                              input logic           sub);
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic [WIDTH:0]   r;
    bx   = sub ? ~b[WIDTH-1:0] : b[WIDTH-1:0];
    g    = a[WIDTH-1:0] & bx;
    p    = a[WIDTH-1:0] ^ bx;
    c[0] = sub;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    r[WIDTH-1:0] = p ^ c[WIDTH-1:0];
    r[WIDTH]     = a[WIDTH] ^ (sub ? ~b[WIDTH] : b[WIDTH]) ^ c[WIDTH];
    return r;
  endfunction

  // Booth recode of {q[0], q_-1}, add/sub into acc, then arithmetic shift right.
  always_comb begin
    acc_sum_s = acc_r;
    case ({q_r[0], qm1_r})
      2'b01:   acc_sum_s = addsub33(acc_r, m_r, 1'b0);
      2'b10:   acc_sum_s = addsub33(acc_r, m_r, 1'b1);
      default: acc_sum_s = acc_r;
    endcase
    acc_sh_s = {acc_sum_s[WIDTH], acc_sum_s[WIDTH:1]};
    q_sh_s   = {acc_sum_s[0], q_r[WIDTH-1:1]};
    qm1_sh_s = q_r[0];
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic plus accept / final-step strobes.
  always_comb begin
    state_s     = state_r;
    accept_s    = 1'b0;
    last_step_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == {CNT_W{1'b1}}) begin
          last_step_s = 1'b1;
          state_s     = DONE;
        end else begin
          state_s     = RUN;
        end
      end
      DONE: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: operand load on accept, one Booth step per RUN cycle, result capture.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      m_r          <= {(WIDTH+1){1'b0}};
      acc_r        <= {(WIDTH+1){1'b0}};
      q_r          <= {WIDTH{1'b0}};
      qm1_r        <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
      result_rdy_r <= 1'b0;
      result_r     <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      m_r          <= {operand_a[WIDTH-1], operand_a};
      acc_r        <= {(WIDTH+1){1'b0}};
      q_r          <= operand_b;
      qm1_r        <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
      result_rdy_r <= 1'b0;
    end else if (state_r == RUN) begin
      acc_r        <= acc_sh_s;
      q_r          <= q_sh_s;
      qm1_r        <= qm1_sh_s;
      // hold at the last count so cnt only returns to 0 on the next accept
      cnt_r        <= last_step_s ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      result_rdy_r <= last_step_s;
      if (last_step_s) begin
        result_r <= q_sh_s;
      end else begin
        result_r <= result_r;
      end
    end else begin
      result_rdy_r <= 1'b0;
    end
  end

`ifdef MULT_OVF_DETECT_EN
  logic overflow_r;

  // Overflow: upper product half is not a pure sign extension of product[31].
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
    end else if (accept_s) begin
      overflow_r <= 1'b0;
    end else if (last_step_s) begin
      overflow_r <= (acc_sh_s[WIDTH-1:0] != {WIDTH{q_sh_s[WIDTH-1]}});
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign overflow = overflow_r;
`else
  assign overflow = 1'b0;
`endif

  assign busy       = (state_r == RUN);
  assign result_rdy = result_rdy_r;
  assign result     = result_r;

endmodule
